// File: rtl/aes_mode_engine.sv
// aes_mode_engine: ECB / CBC-encrypt / CTR streaming wrapper around an iterative AES-128 core.
// Define AES_MODE_STATS_EN to add the saturating blk_cnt output-handshake counter.

module aes_core (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [0:127] key_i,
  input  logic [0:127] text_i,
  output logic [0:127] text_o,
  output logic         ready_o
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) plus affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] p;
    s = a;
    p = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gmul(s, s);
      p = gmul(p, s);
    end
    return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]}
             ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [0:127] key_step(input logic [0:127] k,
                                            input logic [7:0]   rc);
    logic [0:31]  t;
    logic [0:127] n;
    t = {sbox(k[104+:8]) ^ rc, sbox(k[112+:8]),
         sbox(k[120+:8]), sbox(k[96+:8])};
    n[0+:32]  = k[0+:32]  ^ t;
    n[32+:32] = k[32+:32] ^ n[0+:32];
    n[64+:32] = k[64+:32] ^ n[32+:32];
    n[96+:32] = k[96+:32] ^ n[64+:32];
    return n;
  endfunction

  function automatic logic [0:127] aes_round(input logic [0:127] s,
                                             input logic [0:127] rk,
                                             input logic         fin);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [0:127] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[8*i +: 8]);
    for (int c = 0; c < 4; c++)
      for (int j = 0; j < 4; j++)
        t[j + 4*c] = b[j + 4*((c + j) % 4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c];
        a1 = t[4*c + 1];
        a2 = t[4*c + 2];
        a3 = t[4*c + 3];
        t[4*c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        t[4*c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        t[4*c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        t[4*c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = t[i] ^ rk[8*i +: 8];
    return r;
  endfunction

  logic [0:127] st_q, st_d;
  logic [0:127] rk_q, rk_d;
  logic [0:127] nrk;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         run_q, run_d;
  logic         rdy_q, rdy_d;

  assign nrk = key_step(rk_q, rcon_q);

  // One round per cycle; ready pulses once, ten cycles after start
  always_comb begin
    st_d   = st_q;
    rk_d   = rk_q;
    rcon_d = rcon_q;
    rnd_d  = rnd_q;
    run_d  = run_q;
    rdy_d  = 1'b0;
    if (start_i) begin
      st_d   = text_i ^ key_i;
      rk_d   = key_i;
      rcon_d = 8'h01;
      rnd_d  = 4'd1;
      run_d  = 1'b1;
    end else if (run_q) begin
      st_d   = aes_round(st_q, nrk, rnd_q == 4'd10);
      rk_d   = nrk;
      rcon_d = xt(rcon_q);
      rnd_d  = rnd_q + 4'd1;
      if (rnd_q == 4'd10) begin
        run_d = 1'b0;
        rdy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q   <= '0;
      rk_q   <= '0;
      rcon_q <= 8'h00;
      rnd_q  <= 4'd0;
      run_q  <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      rk_q   <= rk_d;
      rcon_q <= rcon_d;
      rnd_q  <= rnd_d;
      run_q  <= run_d;
      rdy_q  <= rdy_d;
    end
  end

  assign text_o  = st_q;
  assign ready_o = rdy_q;

endmodule

module aes_mode_engine #(
  parameter int CTR_WIDTH    = 32,
  parameter int CORE_TIMEOUT = 64
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         init,
  input  logic [1:0]   cfg_mode,
  input  logic [0:127] cfg_key,
  input  logic [0:127] cfg_iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         out_last,
  output logic         busy,
`ifdef AES_MODE_STATS_EN
  output logic [31:0]  blk_cnt,
`endif
  output logic         err
);

  typedef enum logic [2:0] {
    UNINIT, IDLE, START, WAIT, OUT
  } state_e;

  localparam logic [1:0] M_CBC = 2'd1;
  localparam logic [1:0] M_CTR = 2'd2;
  localparam logic [1:0] M_RSV = 2'd3;
  localparam int         TW    = $clog2(CORE_TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [0:127]   key_q, key_d;
  logic [0:127]   chain_q, chain_d;
  logic [0:127]   data_q, data_d;
  logic           last_q, last_d;
  logic [0:127]   odata_q, odata_d;
  logic           olast_q, olast_d;
  logic           err_q, err_d;
  logic [TW-1:0]  wcnt_q, wcnt_d;
`ifdef AES_MODE_STATS_EN
  logic [31:0]    cnt_q, cnt_d;
`endif

  logic           core_start;
  logic           core_rdy;
  logic [0:127]   core_in;
  logic [0:127]   core_out;
  logic [0:127]   ctr_next;

  aes_core u_core (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .start_i (core_start),
    .key_i   (key_q),
    .text_i  (core_in),
    .text_o  (core_out),
    .ready_o (core_rdy)
  );

  always_comb begin
    case (mode_q)
      M_CBC:   core_in = data_q ^ chain_q;
      M_CTR:   core_in = chain_q;
      default: core_in = data_q;
    endcase
  end

  // Only the low CTR_WIDTH bits count; the carry out is dropped
  always_comb begin
    ctr_next = chain_q;
    ctr_next[128-CTR_WIDTH +: CTR_WIDTH] =
      chain_q[128-CTR_WIDTH +: CTR_WIDTH] + CTR_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    key_d      = key_q;
    chain_d    = chain_q;
    data_d     = data_q;
    last_d     = last_q;
    odata_d    = odata_q;
    olast_d    = olast_q;
    err_d      = err_q;
    wcnt_d     = wcnt_q;
`ifdef AES_MODE_STATS_EN
    cnt_d      = cnt_q;
`endif
    core_start = 1'b0;
    in_ready   = 1'b0;
    unique case (state_q)
      UNINIT, IDLE: begin
        if (init) begin
          mode_d  = cfg_mode;
          key_d   = cfg_key;
          chain_d = cfg_iv;
          err_d   = (cfg_mode == M_RSV);
`ifdef AES_MODE_STATS_EN
          cnt_d   = '0;
`endif
          state_d = IDLE;
        end else if (state_q == IDLE) begin
          in_ready = 1'b1;
          if (in_valid) begin
            data_d  = in_data;
            last_d  = in_last;
            state_d = START;
          end
        end
      end
      START: begin
        core_start = 1'b1;
        wcnt_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        if (core_rdy) begin
          olast_d = last_q;
          state_d = OUT;
          case (mode_q)
            M_CBC: begin
              odata_d = core_out;
              chain_d = core_out;
            end
            M_CTR: begin
              odata_d = data_q ^ core_out;
              chain_d = ctr_next;
            end
            default: odata_d = core_out;
          endcase
        end else if (wcnt_q == TW'(CORE_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          odata_d = '0;
          olast_d = last_q;
          state_d = OUT;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef AES_MODE_STATS_EN
          if (cnt_q != 32'hffff_ffff) cnt_d = cnt_q + 32'd1;
`endif
        end
      end
      default: state_d = UNINIT;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= UNINIT;
      mode_q  <= 2'd0;
      key_q   <= '0;
      chain_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      odata_q <= '0;
      olast_q <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
`ifdef AES_MODE_STATS_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      chain_q <= chain_d;
      data_q  <= data_d;
      last_q  <= last_d;
      odata_q <= odata_d;
      olast_q <= olast_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
`ifdef AES_MODE_STATS_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == START) || (state_q == WAIT)
                  || (state_q == OUT);
  assign out_data  = odata_q;
  assign out_last  = olast_q;
  assign err       = err_q;
`ifdef AES_MODE_STATS_EN
  assign blk_cnt   = cnt_q;
`endif

endmodule

// File: tb/tb_aes_mode_engine.sv
// tb_aes_mode_engine: randomized and directed checks of aes_mode_engine
// against a table-driven AES / block-mode reference model.

module tb_aes_mode_engine;

  localparam int LAT = 12;
  localparam int W   = 32;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [95:0]  UP = 96'h0123456789abcdef01234567;

  logic         sys_clk = 1'b0;
  logic         sys_rst_n = 1'b0;
  logic         init = 1'b0;
  logic [1:0]   cfg_mode = 2'd0;
  logic [127:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         err;
`ifdef AES_MODE_STATS_EN
  logic [31:0]  blk_cnt;
  logic [31:0]  m_cnt = '0;
`endif

  always #5 sys_clk = ~sys_clk;

  aes_mode_engine dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init      (init),
    .cfg_mode  (cfg_mode),
    .cfg_key   (cfg_key),
    .cfg_iv    (cfg_iv),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
`ifdef AES_MODE_STATS_EN
    .blk_cnt   (blk_cnt),
`endif
    .err       (err)
  );

  typedef struct {
    logic [127:0] d;
    logic         l;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [7:0]   sb [256];
  bit           m_cfg = 1'b0;
  bit           m_err = 1'b0;
  logic [1:0]   m_mode = 2'd0;
  logic [127:0] m_key = '0;
  logic [127:0] m_chain = '0;
  logic [127:0] last_out = '0;
  bit           rr_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // S-box from the generator walk: p steps by x3, q by its inverse
  task automatic build_sbox;
    logic [7:0] p, qq, x;
    p  = 8'h01;
    qq = 8'h01;
    do begin
      p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ {qq[6:0], 1'b0};
      qq = qq ^ {qq[5:0], 2'b0};
      qq = qq ^ {qq[3:0], 4'b0};
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]}
             ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] m2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] k,
                                           input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] ct;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]],
               sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++)
        t[i] = sb[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < 10) begin
          s[4*c]   = m2(a0) ^ (m2(a1) ^ a1) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m2(a1) ^ (m2(a2) ^ a2) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ (m2(a3) ^ a3);
          s[4*c+3] = (m2(a0) ^ a0) ^ a1 ^ a2 ^ m2(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
    return ct;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_accept(input logic [127:0] d, input logic l);
    logic [127:0] o, mask;
    case (m_mode)
      2'd1: begin
        o = aes_enc(m_key, d ^ m_chain);
        m_chain = o;
      end
      2'd2: begin
        o = d ^ aes_enc(m_key, m_chain);
        mask = (W >= 128) ? '1 : ((128'd1 << W) - 128'd1);
        m_chain = (m_chain & ~mask) | ((m_chain + 128'd1) & mask);
      end
      default: o = aes_enc(m_key, d);
    endcase
    q.push_back('{o, l, cyc + 1});
  endtask

  // All tasks below start and end 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_init(input logic [1:0] m, input logic [127:0] k,
                         input logic [127:0] iv);
    cfg_mode = m;
    cfg_key  = k;
    cfg_iv   = iv;
    init     = 1'b1;
    @(posedge sys_clk);
    m_mode  = m;
    m_key   = k;
    m_chain = iv;
    m_err   = (m == 2'd3);
    m_cfg   = 1'b1;
`ifdef AES_MODE_STATS_EN
    m_cnt   = '0;
`endif
    #1;
    init = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic l);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    n = 0;
    forever begin
      @(negedge sys_clk);
      if (in_ready) break;
      n++;
      if (n > 300) break;
    end
    if (n > 300) begin
      bound_fail("accept");
      @(posedge sys_clk);
    end else begin
      @(posedge sys_clk);
      model_accept(d, l);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      step(1);
      n++;
    end
    if (q.size() != 0) begin
      bound_fail("drain");
      q.delete();
    end
  endtask

  always @(negedge sys_clk) begin : cmp
    bit ev;
    cyc++;
    ev = 1'b0;
    if (q.size() != 0) ev = (cyc >= q[0].acc + LAT);
    chk("in_ready", in_ready, m_cfg && q.size() == 0 && !init);
    chk("busy", busy, q.size() != 0);
    chk("out_valid", out_valid, ev);
    chk("err", err, m_err);
`ifdef AES_MODE_STATS_EN
    chk("blk_cnt", blk_cnt, m_cnt);
`endif
    if (!sys_rst_n) begin
      chk("rst_out_data", out_data, '0);
      chk("rst_out_last", out_last, 1'b0);
    end
    if (ev) begin
      chk("out_data", out_data, q[0].d);
      chk("out_last", out_last, q[0].l);
      if (out_ready) begin
        last_out = out_data;
        q.pop_front();
`ifdef AES_MODE_STATS_EN
        if (m_cnt != 32'hffff_ffff) m_cnt = m_cnt + 32'd1;
`endif
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk);
      #1;
      if (rr_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : main
    logic [127:0] d, k, iv;
    logic [1:0]   m;
    int           nb, n;
    build_sbox();
    chk("model_fips", aes_enc(K0, P0), C0);
    chk("model_zero", aes_enc(128'h0, 128'h0),
        128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    step(3);
    sys_rst_n = 1'b1;
    step(2);
    out_ready = 1'b1;

    do_init(2'd0, K0, '0);
    send(P0, 1'b1);
    drain();
    chk("ecb_dut", last_out, C0);

    do_init(2'd1, K0, '0);
    send(P0, 1'b0);
    drain();
    chk("cbc_b1", last_out, C0);
    send('0, 1'b1);
    drain();
    chk("cbc_b2", last_out, aes_enc(K0, C0));

    do_init(2'd2, K0, P0);
    send('0, 1'b1);
    drain();
    chk("ctr_b1", last_out, C0);
    chk("ctr_next", m_chain, 128'h00112233445566778899aabbccddef00);
    send(P0, 1'b1);
    drain();

    do_init(2'd2, K0, {UP, 32'hffff_ffff});
    send(rnd128(), 1'b0);
    drain();
    chk("ctr_wrap", m_chain, {UP, 32'h0});
    d = rnd128();
    send(d, 1'b1);
    drain();
    chk("ctr_wrap_b2", last_out, d ^ aes_enc(K0, {UP, 32'h0}));

    out_ready = 1'b0;
    send(rnd128(), 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      step(1);
      n++;
    end
    if (!out_valid) bound_fail("bp_valid");
    step(20);
    out_ready = 1'b1;
    drain();
    step(2);

    in_valid = 1'b1;
    in_data  = rnd128();
    do_init(2'd0, K0, '0);
    in_valid = 1'b0;
    step(3);

    do_init(2'd3, K0, '0);
    send(P0, 1'b1);
    drain();
    chk("rsv_ecb", last_out, C0);
    do_init(2'd0, K0, '0);
    step(1);

    do_init(2'd1, K0, P0);
    send(rnd128(), 1'b1);
    step(5);
    sys_rst_n = 1'b0;
    q.delete();
    m_cfg = 1'b0;
    m_err = 1'b0;
`ifdef AES_MODE_STATS_EN
    m_cnt = '0;
`endif
    step(3);
    sys_rst_n = 1'b1;
    step(3);
    do_init(2'd1, K0, '0);
    send(P0, 1'b1);
    drain();
    chk("post_rst_cbc", last_out, C0);

    rr_en = 1'b1;
    for (int r = 0; r < 10; r++) begin
      m  = 2'($urandom_range(0, 3));
      k  = rnd128();
      iv = rnd128();
      if (m == 2'd2) iv[31:0] = 32'hffff_ffff - $urandom_range(0, 2);
      do_init(m, k, iv);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) send(rnd128(), b == nb - 1);
      drain();
    end
    rr_en = 1'b0;
    out_ready = 1'b1;
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
